count_sequencer: RTL and testbench

Controller that sequences the team's 4-bit loadable up/down counter through programmed count runs. It accepts a command (start value, stop value, direction, step divider) over a valid/ready handshake and loads the counter. It then enables the counter every (div+1) clocks until the counter output equals the stop value, and pulses `done`. It sits between a host/control FSM and the counter, and is the only driver of the counter's `load`, `data_in`, `en` and `mode` pins.

---
 rtl/count_sequencer.sv | 95 +++++++++
 tb/tb_count_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: runs a 4-bit loadable up/down counter from a start to a stop value,
// stepping every (div+1) clocks, then pulses done_o.
// Optional feature macro: COUNT_SEQ_REPEAT_EN (when defined, a latched repeat request
// reruns the same command after every done_o pulse until abort_i).
module count_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_start_i,
  input  logic [3:0]       cmd_stop_i,
  input  logic             cmd_dir_i,
  input  logic [DIV_W-1:0] cmd_div_i,
  input  logic             cmd_repeat_i,
  input  logic             abort_i,
  output logic             cnt_load_o,
  output logic [3:0]       cnt_data_o,
  output logic             cnt_en_o,
  output logic             cnt_mode_o,
  input  logic [3:0]       cnt_q_i,
  output logic             busy_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [3:0]       start_q, start_d, stop_q, stop_d;
  logic             dir_q, dir_d, rep_q, rep_d;
  logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic             at_stop, rerun;
`ifdef COUNT_SEQ_REPEAT_EN
  assign rerun = rep_q;
`else
  logic rep_unused;
  assign rerun = 1'b0;
  assign rep_unused = rep_q;
`endif
  // state, latched command fields and divider counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      dir_q     <= 1'b0;
      rep_q     <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      dir_q     <= dir_d;
      rep_q     <= rep_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
    end
  end
  // next state and counter-facing outputs; abort overrides everything outside IDLE
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    stop_d      = stop_q;
    dir_d       = dir_q;
    rep_d       = rep_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    at_stop     = cnt_q_i == stop_q;
    cmd_ready_o = state_q == IDLE;
    busy_o      = state_q != IDLE;
    cnt_data_o  = start_q;
    cnt_mode_o  = dir_q;
    cnt_load_o  = state_q == LOAD && !abort_i;
    cnt_en_o    = state_q == RUN && !at_stop && div_cnt_q == div_q && !abort_i;
    done_o      = state_q == DONE && !abort_i;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        start_d = cmd_start_i;
        stop_d  = cmd_stop_i;
        dir_d   = cmd_dir_i;
        rep_d   = cmd_repeat_i;
        div_d   = cmd_div_i;
        state_d = LOAD;
      end
      LOAD: begin
        div_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: if (at_stop) state_d = DONE;
           else div_cnt_d = div_cnt_q == div_q ? '0 : div_cnt_q + DIV_W'(1);
      default: state_d = rerun ? LOAD : IDLE;
    endcase
    if (abort_i && state_q != IDLE) state_d = IDLE;
  end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench; stimulus queues expected load/enable/done cycles,
// a negedge monitor pops and compares them whenever the DUT asserts those outputs.
module tb_count_sequencer;
  logic       clk = 1'b0, resetn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_repeat = 1'b0, abort = 1'b0;
  logic [3:0] cmd_start = '0, cmd_stop = '0, cnt_q = '0, cnt_data;
  logic [7:0] cmd_div = '0;
  logic       cmd_ready, cnt_load, cnt_en, cnt_mode, busy, done;
  int         cyc = 0, compared = 0, mismatched = 0;
  int         qload[$], qen[$], qdone[$];
  logic [3:0] exp_start = '0, exp_stop = '0;
  logic       exp_dir = 1'b0;

  count_sequencer #(.DIV_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_dir_i(cmd_dir),
    .cmd_div_i(cmd_div), .cmd_repeat_i(cmd_repeat), .abort_i(abort),
    .cnt_load_o(cnt_load), .cnt_data_o(cnt_data), .cnt_en_o(cnt_en), .cnt_mode_o(cnt_mode),
    .cnt_q_i(cnt_q), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // the counter being sequenced: no reset, keeps its value unless loaded or enabled
  always @(posedge clk)
    if (cnt_load) cnt_q <= cnt_data;
    else if (cnt_en) cnt_q <= cnt_mode ? cnt_q + 4'd1 : cnt_q - 4'd1;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pop expected cycle numbers whenever the DUT drives the counter or signals done
  always @(negedge clk) if (resetn) begin
    if (cnt_load && cnt_en) chk("load_en_overlap", 1, 0);
    if (cnt_load) begin
      if (qload.size() == 0) chk("unexpected_load", cyc, -1);
      else chk("load_cycle", cyc, qload.pop_front());
    end
    if (cnt_en) begin
      if (qen.size() == 0) chk("unexpected_en", cyc, -1);
      else chk("en_cycle", cyc, qen.pop_front());
    end
    if (done) begin
      if (qdone.size() == 0) chk("unexpected_done", cyc, -1);
      else chk("done_cycle", cyc, qdone.pop_front());
      chk("done_cnt_q", cnt_q, exp_stop);
    end
    if (busy) begin
      chk("cnt_data", cnt_data, exp_start);
      chk("cnt_mode", cnt_mode, exp_dir);
    end
  end

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_load"}, cnt_load, 0);
    chk({tag, "_en"}, cnt_en, 0);
    chk({tag, "_mode"}, cnt_mode, 0);
    chk({tag, "_data"}, cnt_data, 0);
  endtask

  // offer a command on the next cycle and queue its expected timeline
  // ne<0 queues every enable pulse; pd selects whether a done pulse is expected
  task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic d,
                       input logic [7:0] dv, input logic r, input int ne, input bit pd,
                       output int a, output int n);
    logic [3:0] t;
    @(posedge clk);
    #1;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_start = s; cmd_stop = e; cmd_dir = d; cmd_div = dv; cmd_repeat = r; cmd_valid = 1'b1;
    exp_start = s; exp_stop = e; exp_dir = d;
    a = cyc + 1;
    t = d ? e - s : s - e;
    n = int'(t);
    qload.push_back(a);
    for (int j = 0; j < n && (ne < 0 || j < ne); j++) qen.push_back(a + 1 + dv + j * (dv + 1));
    if (pd) qdone.push_back(a + 2 + n * (dv + 1));
  endtask

  task automatic run(input logic [3:0] s, input logic [3:0] e, input logic d,
                     input logic [7:0] dv, input bit hold);
    int a, n;
    issue(s, e, d, dv, 1'b0, -1, 1'b1, a, n);
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_start = ~s;
      cmd_stop = ~e;
      wait_cyc(a + 2 + n * (dv + 1));
      chk("held_not_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    wait_cyc(a + 3 + n * (dv + 1));
    chk("ready_after_run", cmd_ready, 1);
    chk("busy_after_run", busy, 0);
    chk("final_cnt_q", cnt_q, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, n;
    #3;
    check_reset_outputs("reset");
    #20 resetn = 1'b1;
    // up run with cmd_valid held (and fields changed) while busy
    run(4'd3, 4'd7, 1'b1, 8'd0, 1'b1);
    // wrap-around, down, divided
    run(4'd1, 4'd14, 1'b0, 8'd2, 1'b0);
    // zero-step run
    run(4'd9, 4'd9, 1'b1, 8'd0, 1'b0);
    // up wrap with divider
    run(4'd14, 4'd1, 1'b1, 8'd1, 1'b0);
    // abort in the third RUN cycle
    issue(4'd0, 4'd15, 1'b1, 8'd0, 1'b0, 2, 1'b0, a, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_cyc(a + 3);
    abort = 1'b1;
    #1;
    chk("abort_en_gate", cnt_en, 0);
    chk("abort_done_gate", done, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_q", cnt_q, 2);
    wait_cyc(a + 8);
    chk("abort_cnt_frozen", cnt_q, 2);
    // asynchronous reset in the middle of a run
    issue(4'd5, 4'd12, 1'b1, 8'd1, 1'b0, 2, 1'b0, a, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_cyc(a + 5);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    qload.delete(); qen.delete(); qdone.delete();
    exp_start = '0; exp_stop = '0; exp_dir = 1'b0;
    #20 resetn = 1'b1;
    run(4'd6, 4'd2, 1'b0, 8'd0, 1'b0);
    // repeat request
`ifdef COUNT_SEQ_REPEAT_EN
    issue(4'd2, 4'd4, 1'b1, 8'd0, 1'b1, 0, 1'b0, a, n);
    qload.push_back(a + 5); qload.push_back(a + 10);
    qen.push_back(a + 1); qen.push_back(a + 2); qen.push_back(a + 6); qen.push_back(a + 7);
    qdone.push_back(a + 4); qdone.push_back(a + 9);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_cyc(a + 5);
    chk("repeat_busy", busy, 1);
    wait_cyc(a + 11);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("repeat_abort_ready", cmd_ready, 1);
    wait_cyc(a + 20);
    chk("repeat_stopped_busy", busy, 0);
`else
    issue(4'd2, 4'd4, 1'b1, 8'd0, 1'b1, -1, 1'b1, a, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_cyc(a + 5);
    chk("norepeat_ready", cmd_ready, 1);
    wait_cyc(a + 15);
    chk("norepeat_idle", busy, 0);
`endif
    chk("left_load", qload.size(), 0);
    chk("left_en", qen.size(), 0);
    chk("left_done", qdone.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
